key_led_array: RTL and testbench
================================

KEY_LED_ARRAY -- requirements
Module: key_led_array

Interface
REQ-001 Parameter KEY_NUM, default 2: number of key/LED channels, legal range 1..16.
REQ-002 Parameter CNT_MAX, default 25'd999_999: debounce filter length in sys_clk cycles, legal minimum 2.
REQ-003 Parameter LONG_MAX, default 32'd49_999_999: long-press threshold in sys_clk cycles after debounced press, must exceed CNT_MAX.
REQ-004 Parameter LED_MODE, default 1: 0 = FOLLOW, 1 = TOGGLE.
REQ-005 sys_clk  input  1  single system clock, all logic rising-edge.
REQ-006 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 key  input  KEY_NUM  raw asynchronous mechanical keys, active-low (1 = released).
REQ-008 led  output  KEY_NUM  LED drive, active-high (1 = lit).
REQ-009 key_press  output  KEY_NUM  one-cycle pulse per debounced press.
REQ-010 key_release  output  KEY_NUM  one-cycle pulse per debounced release.
REQ-011 key_long  output  KEY_NUM  one-cycle pulse when a press reaches LONG_MAX.

Function
REQ-012 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per channel, FSM SHALL have states IDLE, FILT_DN, PRESSED, FILT_UP.
REQ-014 IDLE: synced key 0 -> FILT_DN with debounce counter cleared to 0.
REQ-015 FILT_DN: counter increments per cycle while synced key 0; synced key 1 -> IDLE, counter cleared.
REQ-016 FILT_DN with counter == CNT_MAX-1 and synced key 0 -> PRESSED, key_press pulsed in the next cycle, long counter cleared.
REQ-017 PRESSED: long counter increments per cycle, saturates; key_long pulses exactly once per press when long counter reaches LONG_MAX-1.
REQ-018 PRESSED: synced key 1 -> FILT_UP, debounce counter cleared; long counter held.
REQ-019 FILT_UP: synced key 0 -> PRESSED (no key_press pulse, long counter resumes); counter == CNT_MAX-1 with synced key 1 -> IDLE, key_release pulsed.
REQ-020 Press latency: key_press SHALL assert exactly CNT_MAX+2 cycles after the first sys_clk edge sampling key low, given key held low throughout.
REQ-021 Bounce shorter than CNT_MAX cycles SHALL produce no pulse and no LED change.
REQ-022 FOLLOW: led[i] = 1 in PRESSED and FILT_UP, else 0.
REQ-023 TOGGLE: led[i] inverts on key_press[i]; key_long on any channel clears all led bits to 0.
REQ-024 TOGGLE simultaneous events: clear has priority; toggles in the same cycle are discarded.
REQ-025 Channels SHALL be fully independent; simultaneous presses on several keys each produce their own pulses.
REQ-026 Counter widths SHALL be derived from CNT_MAX and LONG_MAX via clog2, no wrap-around.

Reset
REQ-027 sys_rst_n low on a sys_clk edge: synchronizers to 1, FSMs to IDLE, counters to 0, led/key_press/key_release/key_long to 0.
REQ-028 Reset asserted mid-filter or mid-press SHALL abort with no pulse; after release a held-low key is debounced anew from IDLE.

Structure
REQ-029 Shared package key_pkg SHALL hold FSM state encoding and LED_MODE constants FOLLOW/TOGGLE.
REQ-030 Per-channel synchronizer+FSM+counters SHALL be sub-module key_debounce, instantiated KEY_NUM times by generate; LED logic in top.

Verification (KEY_NUM=2, CNT_MAX=25, LONG_MAX=100, 20 ns clock)
REQ-031 Reset 200 ns with key=2'b11, then idle 2000 ns -> led=2'b00, no pulses.
REQ-032 key=2'b10 held 2000 ns, TOGGLE -> key_press[0] single pulse 27 cycles after sampling, led=2'b01; release -> key_release[0] pulse, led stays 2'b01.
REQ-033 key[1] toggled every 5 cycles for 200 cycles then held low -> no pulse during bounce, one key_press[1] after settling.
REQ-034 key[0] held low 3000 ns, TOGGLE -> key_press at 27 cycles, key_long[0] at cycle 127, led=2'b00 after long.
REQ-035 FOLLOW: key=2'b01 2000 ns -> led[1]=1 from press pulse until release pulse, led[0]=0.
REQ-036 Reset asserted at cycle 15 of FILT_DN -> no key_press, all outputs 0, fresh 27-cycle latency after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key/LED array: debounce FSM state encoding
// and the LED behaviour selector values.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        PRESSED = 2'd2,
        FILT_UP = 2'd3
    } key_state_t;

    localparam int FOLLOW = 0;
    localparam int TOGGLE = 1;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce FSM, and a saturating
// long-press counter producing registered one-cycle event pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = 25'd999_999,
    parameter int unsigned LONG_MAX = 32'd49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic press,
    output logic rel,
    output logic long_hit,
    output logic held
);

    localparam int CW = $clog2(CNT_MAX);
    localparam int LW = $clog2(LONG_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
    localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_MAX);

    logic [1:0]    sync;
    logic          synced;
    key_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [LW-1:0] long_cnt, long_n;
    logic          press_n, rel_n, long_hit_n;

    assign synced = sync[1];
    assign held   = (state == PRESSED) || (state == FILT_UP);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync     <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            long_cnt <= '0;
            press    <= 1'b0;
            rel      <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            sync     <= {sync[0], key};
            state    <= state_n;
            cnt      <= cnt_n;
            long_cnt <= long_n;
            press    <= press_n;
            rel      <= rel_n;
            long_hit <= long_hit_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        long_n     = long_cnt;
        press_n    = 1'b0;
        rel_n      = 1'b0;
        long_hit_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (!synced) begin
                    state_n = FILT_DN;
                    cnt_n   = '0;
                end
            end
            FILT_DN: begin
                if (synced) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    long_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (synced) begin
                    state_n = FILT_UP;
                    cnt_n   = '0;
                end else begin
                    // Saturating one past the threshold keeps the pulse single
                    if (long_cnt < LONG_TOP) begin
                        long_n = long_cnt + 1'b1;
                    end
                    long_hit_n = (long_cnt == LONG_LAST);
                end
            end
            FILT_UP: begin
                if (!synced) begin
                    state_n = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/key_led_array.sv
// Array of independently debounced keys driving LEDs either directly
// (FOLLOW) or as toggles cleared by any long press (TOGGLE).
module key_led_array
    import key_pkg::*;
#(
    parameter int          KEY_NUM  = 2,
    parameter int unsigned CNT_MAX  = 25'd999_999,
    parameter int unsigned LONG_MAX = 32'd49_999_999,
    parameter int          LED_MODE = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] led,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    logic [KEY_NUM-1:0] held;
    logic [KEY_NUM-1:0] led_q;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce #(
            .CNT_MAX (CNT_MAX),
            .LONG_MAX(LONG_MAX)
        ) u_deb (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .key      (key[i]),
            .press    (key_press[i]),
            .rel      (key_release[i]),
            .long_hit (key_long[i]),
            .held     (held[i])
        );
    end

    // A long press anywhere wins over toggles landing in the same cycle
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            led_q <= '0;
        end else if (|key_long) begin
            led_q <= '0;
        end else begin
            led_q <= led_q ^ key_press;
        end
    end

    assign led = (LED_MODE == FOLLOW) ? held : led_q;

endmodule

// File: tb/tb_key_led_array.sv
// Randomized and directed bench for key_led_array with a scoreboard
// fed by a level/run-length reference model of the debounced keys.
module tb_key_led_array;
    import key_pkg::*;

    localparam int N    = 2;
    localparam int CMAX = 25;
    localparam int LMAX = 100;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] key;
    logic [N-1:0] led_t, press_t, rel_t, long_t;
    logic [N-1:0] led_f, press_f, rel_f, long_f;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic [N-1:0] lt;
        logic [N-1:0] lf;
    } exp_t;

    exp_t exp_q[$];

    key_led_array #(
        .KEY_NUM(N), .CNT_MAX(CMAX), .LONG_MAX(LMAX), .LED_MODE(TOGGLE)
    ) dut_t (
        .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .led(led_t),
        .key_press(press_t), .key_release(rel_t), .key_long(long_t)
    );

    key_led_array #(
        .KEY_NUM(N), .CNT_MAX(CMAX), .LONG_MAX(LMAX), .LED_MODE(FOLLOW)
    ) dut_f (
        .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .led(led_f),
        .key_press(press_f), .key_release(rel_f), .key_long(long_f)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: a key's debounced level flips once CMAX+1 consecutive
    // synchronized samples disagree with it; long fires on the LMAX-th
    // pair of consecutive low samples seen while pressed.
    logic [N-1:0] s1, s2, lsyn, syn, lvl, m_led, p, r, l;
    int run[N];
    int lcnt[N];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                s1 = '1; s2 = '1; lsyn = '1;
                lvl = '0; m_led = '0; p = '0; r = '0; l = '0;
                for (int i = 0; i < N; i++) begin
                    run[i] = 0;
                    lcnt[i] = 0;
                end
            end else begin
                if (|l) m_led = '0;
                else m_led = m_led ^ p;
                syn = s2; s2 = s1; s1 = key;
                p = '0; r = '0; l = '0;
                for (int i = 0; i < N; i++) begin
                    if (lvl[i] && !syn[i] && !lsyn[i]) begin
                        lcnt[i]++;
                        if (lcnt[i] == LMAX) l[i] = 1'b1;
                    end
                    if (lvl[i] ? syn[i] : !syn[i]) run[i]++;
                    else run[i] = 0;
                    if (run[i] == CMAX + 1) begin
                        run[i] = 0;
                        if (lvl[i]) r[i] = 1'b1;
                        else begin
                            p[i] = 1'b1;
                            lcnt[i] = 0;
                        end
                        lvl[i] = !lvl[i];
                    end
                end
                lsyn = syn;
            end
            exp_q.push_back('{p: p, r: r, l: l, lt: m_led, lf: lvl});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("press_t", press_t, e.p);
                check("release_t", rel_t, e.r);
                check("long_t", long_t, e.l);
                check("led_toggle", led_t, e.lt);
                check("press_f", press_f, e.p);
                check("release_f", rel_f, e.r);
                check("long_f", long_f, e.l);
                check("led_follow", led_f, e.lf);
            end
        end
    end

    // Edge 0 is the first rising edge after the call; returns -1 if unseen
    task automatic measure(input int ch, input int n,
                           output int kp, output int kr, output int kl);
        kp = -1; kr = -1; kl = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (kp < 0 && press_t[ch]) kp = k;
            if (kr < 0 && rel_t[ch]) kr = k;
            if (kl < 0 && long_t[ch]) kl = k;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int kp, kr, kl;
        int rem[N];
        rst_n = 1'b0;
        key   = 2'b11;
        cycles(10);
        rst_n = 1'b1;
        cycles(100);
        check("idle_led", led_t, 0);

        key = 2'b10;
        measure(0, 100, kp, kr, kl);
        check("press_latency", kp, 27);
        check("led_after_press", led_t, 1);
        key = 2'b11;
        measure(0, 60, kp, kr, kl);
        check("release_latency", kr, 27);
        check("no_press_on_release", kp, -1);
        check("led_kept", led_t, 1);

        key = 2'b10;
        measure(0, 160, kp, kr, kl);
        check("long_press_latency", kp, 27);
        check("long_latency", kl, 127);
        check("led_after_long", led_t, 0);
        key = 2'b11;
        cycles(60);

        key = 2'b10;
        cycles(100);
        key = 2'b00;
        measure(1, 40, kp, kr, kl);
        check("press_vs_long", kp, 27);
        check("clear_priority", led_t, 0);
        key = 2'b11;
        cycles(60);

        for (int i = 0; i < 40; i++) begin
            key[1] = ~key[1];
            cycles(5);
        end
        key[1] = 1'b0;
        measure(1, 40, kp, kr, kl);
        check("bounce_press", kp, 27);
        key = 2'b11;
        cycles(60);

        key = 2'b01;
        measure(1, 60, kp, kr, kl);
        check("follow_press", kp, 27);
        check("follow_led", led_f, 2);
        key = 2'b11;
        measure(1, 60, kp, kr, kl);
        check("follow_release", kr, 27);
        check("follow_led_off", led_f, 0);

        key = 2'b10;
        cycles(17);
        rst_n = 1'b0;
        cycles(3);
        check("reset_led", led_t, 0);
        rst_n = 1'b1;
        measure(0, 40, kp, kr, kl);
        check("post_reset_press", kp, 27);
        key = 2'b11;
        cycles(60);

        rem = '{0, 0};
        for (int c = 0; c < 6000; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (rem[ch] == 0) begin
                    key[ch] = ~key[ch];
                    rem[ch] = ($urandom_range(0, 9) < 6) ?
                              int'($urandom_range(1, 30)) :
                              int'($urandom_range(30, 160));
                end
                rem[ch]--;
            end
            rst_n = ($urandom_range(0, 999) != 0);
            cycles(1);
        end

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
